// File: rtl/perc_pkg.sv
// perc_pkg: shared parameters, types and the saturating weight step for perceptron training.
package perc_pkg;
  localparam int W_BITS = 8;
  localparam int HIST_LEN = 12;
  localparam int NUM_W = HIST_LEN + 1;
  localparam int IDX_W = 4;
  localparam int THETA = 37;
  localparam int SUM_W = W_BITS + $clog2(NUM_W);
  typedef logic signed [W_BITS-1:0] weight_t;
  typedef logic [NUM_W-1:0][W_BITS-1:0] weight_vec_t;
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [HIST_LEN-1:0] hist;
    logic taken;
  } upd_t;
  localparam int UPD_W = $bits(upd_t);
  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
  function automatic weight_t sat_inc_dec(weight_t w, logic up);
    return up ? ((w == {1'b0, {(W_BITS-1){1'b1}}}) ? w : w + 1'b1)
              : ((w == {1'b1, {(W_BITS-1){1'b0}}}) ? w : w - 1'b1);
  endfunction
endpackage

// File: rtl/perc_upd_fifo.sv
// perc_upd_fifo: synchronous FIFO of pending training updates, commit order preserved.
module perc_upd_fifo
  import perc_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [UPD_W-1:0] din,
  output logic [UPD_W-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(QDEPTH);
  logic [UPD_W-1:0] mem [QDEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head = mem[rp_q[AW-1:0]];
  always_comb begin
    wp_d = wp_q + (AW+1)'(push && !full);
    rp_d = rp_q + (AW+1)'(pop && !empty);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full) mem[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/perc_train_ctrl.sv
// perc_train_ctrl: queues commit updates needing training and applies saturating
// read-modify-write steps to the perceptron weight table, one row per 4 cycles.
module perc_train_ctrl
  import perc_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      train_en,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [IDX_W-1:0]          upd_index,
  input  logic [HIST_LEN-1:0]       upd_hist,
  input  logic                      upd_taken,
  input  logic [SUM_W-1:0]          upd_y,
  output logic [IDX_W-1:0]          rd_index,
  input  logic [NUM_W*W_BITS-1:0]   rd_weights,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_index,
  output logic [NUM_W*W_BITS-1:0]   wr_weights,
  output logic                      busy,
  output logic [15:0]               trained_cnt,
  output logic [15:0]               skipped_cnt
);
  localparam logic signed [SUM_W-1:0] THETA_S = SUM_W'(THETA);
  state_t state_q, state_d;
  logic [IDX_W-1:0] rd_index_q, rd_index_d, wr_index_q, wr_index_d;
  weight_vec_t row_q, row_d, wr_weights_q, wr_weights_d, new_row;
  logic wr_en_q, wr_en_d;
  logic [15:0] trained_q, trained_d, skipped_q, skipped_d;
  logic empty, full, accept, need, pop;
  logic signed [SUM_W-1:0] y;
  logic [UPD_W-1:0] head_bits;
  upd_t head;
  assign y = upd_y;
  // y == 0 counts as a taken prediction
  assign need = ((!y[SUM_W-1]) != upd_taken) || (y <= THETA_S && y >= -THETA_S);
  assign upd_ready = !full;
  assign accept = upd_valid && upd_ready;
  assign pop = state_q == WRITE;
  assign head = upd_t'(head_bits);
  perc_upd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(accept && need), .pop(pop),
    .din({upd_index, upd_hist, upd_taken}), .head(head_bits), .empty(empty), .full(full)
  );
  always_comb begin
    new_row[0] = sat_inc_dec(row_q[0], head.taken);
    for (int i = 1; i < NUM_W; i++) new_row[i] = sat_inc_dec(row_q[i], head.hist[i-1] == head.taken);
  end
  always_comb begin
    state_d = state_q;
    rd_index_d = rd_index_q;
    row_d = row_q;
    wr_index_d = wr_index_q;
    wr_weights_d = wr_weights_q;
    wr_en_d = 1'b0;
    trained_d = (pop && trained_q != 16'hFFFF) ? trained_q + 16'd1 : trained_q;
    skipped_d = (accept && !need && skipped_q != 16'hFFFF) ? skipped_q + 16'd1 : skipped_q;
    case (state_q)
      IDLE: if (!empty && train_en) begin
        state_d = READ;
        rd_index_d = head.index;
      end
      READ: begin
        state_d = CALC;
        row_d = rd_weights;
      end
      CALC: begin
        state_d = WRITE;
        wr_en_d = 1'b1;
        wr_index_d = head.index;
        wr_weights_d = new_row;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_index_q <= '0;
      row_q <= '0;
      wr_index_q <= '0;
      wr_weights_q <= '0;
      wr_en_q <= 1'b0;
      trained_q <= '0;
      skipped_q <= '0;
    end else begin
      state_q <= state_d;
      rd_index_q <= rd_index_d;
      row_q <= row_d;
      wr_index_q <= wr_index_d;
      wr_weights_q <= wr_weights_d;
      wr_en_q <= wr_en_d;
      trained_q <= trained_d;
      skipped_q <= skipped_d;
    end
  end
  assign rd_index = rd_index_q;
  assign wr_en = wr_en_q;
  assign wr_index = wr_index_q;
  assign wr_weights = wr_weights_q;
  assign busy = (state_q != IDLE) || !empty;
  assign trained_cnt = trained_q;
  assign skipped_cnt = skipped_q;
endmodule
